// File: rtl/attention_score_drain.sv
// Walks the T x T score matrix in raster order, issues credit-limited reads on the score port,
// buffers the in-order returns in a small FIFO and streams tagged scores out on valid/ready.
module attention_score_drain #(
  parameter int T          = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int T_W       = (T <= 1) ? 1 : $clog2(T)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_unexp,
  output logic              score_re,
  output logic [T_W-1:0]    score_tq,
  output logic [T_W-1:0]    score_tk,
  input  logic [DATA_W-1:0] score_rdata,
  input  logic              score_rvalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [T_W-1:0]    out_tq,
  output logic [T_W-1:0]    out_tk,
  output logic              out_last_row,
  output logic              out_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [T_W-1:0] IDX_LAST  = T_W'(T - 1);
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [T_W-1:0]    iss_tq, iss_tk;
  logic [T_W-1:0]    rsp_tq, rsp_tk;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [T_W-1:0]    fifo_tq   [FIFO_DEPTH];
  logic [T_W-1:0]    fifo_tk   [FIFO_DEPTH];

  logic [CNT_W:0]    in_use;
  logic              issue, ret, pop, iss_last;

  function automatic logic [2*T_W-1:0] next_idx(input logic [T_W-1:0] tq,
                                                input logic [T_W-1:0] tk);
    if (tk == IDX_LAST) return {tq + T_W'(1), {T_W{1'b0}}};
    return {tq, tk + T_W'(1)};
  endfunction

  // Reads in flight plus buffered entries bound the FIFO occupancy, so a return can never overflow it.
  assign in_use   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign issue    = (state == ISSUE) && (in_use < DEPTH_EXT);
  assign ret      = score_rvalid && (outstanding != '0);
  assign iss_last = (iss_tq == IDX_LAST) && (iss_tk == IDX_LAST);

  assign out_valid    = (fifo_count != '0);
  assign out_data     = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_tq       = out_valid ? fifo_tq[rd_ptr]   : '0;
  assign out_tk       = out_valid ? fifo_tk[rd_ptr]   : '0;
  assign out_last_row = out_valid && (out_tk == IDX_LAST);
  assign out_last     = out_valid && (out_tq == IDX_LAST) && (out_tk == IDX_LAST);
  assign pop          = out_valid && out_ready;

  // Control: sequencing, request register, credit and FIFO bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_unexp   <= 1'b0;
      score_re    <= 1'b0;
      score_tq    <= '0;
      score_tk    <= '0;
      iss_tq      <= '0;
      iss_tk      <= '0;
      rsp_tq      <= '0;
      rsp_tk      <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      done     <= 1'b0;
      score_re <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            iss_tq    <= '0;
            iss_tk    <= '0;
            rsp_tq    <= '0;
            rsp_tk    <= '0;
            err_unexp <= 1'b0;
          end
        end
        ISSUE: begin
          if (issue) begin
            score_re         <= 1'b1;
            score_tq         <= iss_tq;
            score_tk         <= iss_tk;
            {iss_tq, iss_tk} <= next_idx(iss_tq, iss_tk);
            if (iss_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // A stray return is flagged after the start clear so it is never lost.
      if (score_rvalid && (outstanding == '0)) err_unexp <= 1'b1;

      case ({issue, ret})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (ret) begin
        {rsp_tq, rsp_tk} <= next_idx(rsp_tq, rsp_tk);
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({ret, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Return FIFO storage: data path, written on each accepted return
  always_ff @(posedge clk) begin
    if (ret) begin
      fifo_data[wr_ptr] <= score_rdata;
      fifo_tq[wr_ptr]   <= rsp_tq;
      fifo_tk[wr_ptr]   <= rsp_tk;
    end
  end

endmodule

// File: tb/tb_attention_score_drain.sv
// Scoreboard bench for attention_score_drain: randomized return latency/backpressure against a
// raster-order reference model, plus reset, stray-return and single-token cases.
module tb_attention_score_drain;

  localparam int T  = 8;
  localparam int DW = 32;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, busy, done, err_unexp, score_re;
  logic [2:0]    score_tq, score_tk, out_tq, out_tk;
  logic [DW-1:0] score_rdata, out_data;
  logic          score_rvalid, out_valid, out_ready, out_last_row, out_last;

  logic          s1_start, s1_busy, s1_done, s1_err, s1_re, s1_rvalid, s1_valid, s1_ready;
  logic          s1_last_row, s1_last;
  logic [0:0]    s1_tq, s1_tk, s1_otq, s1_otk;
  logic [DW-1:0] s1_rdata, s1_data;

  attention_score_drain #(.T(T), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err_unexp(err_unexp),
    .score_re(score_re), .score_tq(score_tq), .score_tk(score_tk), .score_rdata(score_rdata),
    .score_rvalid(score_rvalid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tq(out_tq), .out_tk(out_tk), .out_last_row(out_last_row),
    .out_last(out_last));

  attention_score_drain #(.T(1), .DATA_W(DW), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .busy(s1_busy), .done(s1_done),
    .err_unexp(s1_err), .score_re(s1_re), .score_tq(s1_tq), .score_tk(s1_tk),
    .score_rdata(s1_rdata), .score_rvalid(s1_rvalid), .out_valid(s1_valid),
    .out_ready(s1_ready), .out_data(s1_data), .out_tq(s1_otq), .out_tk(s1_otk),
    .out_last_row(s1_last_row), .out_last(s1_last));

  typedef struct packed {
    logic [DW-1:0] d;
    logic [2:0]    tq;
    logic [2:0]    tk;
    logic          lr;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] score_mem [T][T];
  int            n_vec = 0, n_fail = 0;
  int            cyc = 0;
  int            lat_lo = 1, lat_hi = 1, rdy_mode = 0, stall_left = 0;
  bit            resp_flush = 0, inject = 0;
  int            mon_issued = 0, mon_popped = 0, req_cnt = 0, done_cnt = 0, last_pop_cyc = -10;
  int            rq_tq[$], rq_tk[$], rq_due[$];
  int            last_due = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory-side responder: in-order returns, per-request random latency
  initial begin
    score_rvalid = 1'b0;
    score_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      score_rvalid = 1'b0;
      score_rdata  = $urandom;
      if (resp_flush) begin
        rq_tq.delete(); rq_tk.delete(); rq_due.delete();
        last_due = 0;
      end else begin
        if (inject) begin
          score_rvalid = 1'b1;
          score_rdata  = 32'hDEAD_BEEF;
        end else if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
          score_rvalid = 1'b1;
          score_rdata  = score_mem[rq_tq[0]][rq_tk[0]];
          void'(rq_tq.pop_front()); void'(rq_tk.pop_front()); void'(rq_due.pop_front());
        end
        if (score_re) begin
          int due;
          due = cyc + int'($urandom_range(lat_hi, lat_lo));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          rq_tq.push_back(int'(score_tq));
          rq_tk.push_back(int'(score_tk));
          rq_due.push_back(due);
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end else out_ready = 1'b1;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: request order, credit bound, hold-under-stall, scoreboard pops, done timing
  initial begin
    logic [63:0] prev_vec;
    bit          prev_hold;
    prev_hold = 0;
    prev_vec  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_issued = 0; mon_popped = 0; req_cnt = 0;
        exp_q.delete();
        prev_hold = 0;
      end else begin
        if (score_re) begin
          chk("req_tag", {58'd0, score_tq, score_tk},
              64'(((req_cnt % (T*T)) / T) * 8 + (req_cnt % T)));
          req_cnt++;
          mon_issued++;
        end
        if (busy) chk("inflight_le_depth", 64'((mon_issued - mon_popped) <= FD), 64'd1);
        if (prev_hold)
          chk("stall_hold", {23'd0, out_valid, out_data, out_tq, out_tk, out_last_row, out_last},
              prev_vec);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", {24'd0, out_data, out_tq, out_tk, out_last_row, out_last}, 64'd0);
            chk("unexpected_out_count", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_elem", {24'd0, out_data, out_tq, out_tk, out_last_row, out_last}, 64'(e));
          end
          mon_popped++;
          last_pop_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          chk("done_after_last_pop", 64'(cyc - last_pop_cyc), 64'd1);
          chk("busy_low_with_done", {63'd0, busy}, 64'd0);
        end
        prev_hold = out_valid && !out_ready;
        prev_vec  = {23'd0, out_valid, out_data, out_tq, out_tk, out_last_row, out_last};
      end
    end
  end

  task automatic load_run(input bit rnd);
    for (int q = 0; q < T; q++)
      for (int k = 0; k < T; k++) begin
        exp_t e;
        score_mem[q][k] = rnd ? $urandom : DW'(q * 16 + k);
        e.d  = score_mem[q][k];
        e.tq = 3'(q);
        e.tk = 3'(k);
        e.lr = (k == T - 1);
        e.l  = (q == T - 1) && (k == T - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_drain(input int llo, input int lhi, input int rmode,
                           input bit second_start, input bit rnd);
    int done_base, pop_base, iss_base, k;
    lat_lo = llo; lat_hi = lhi; rdy_mode = rmode;
    stall_left = (rmode == 2) ? 20 : 0;
    load_run(rnd);
    done_base = done_cnt; pop_base = mon_popped; iss_base = mon_issued;
    pulse_start();
    #1;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("err_cleared_by_start", {63'd0, err_unexp}, 64'd0);
    if (rmode == 2) begin
      repeat (12) @(negedge clk);
      #1;
      chk("stall_issue_count", 64'(mon_issued - iss_base), 64'(FD));
      chk("stall_no_pops", 64'(mon_popped - pop_base), 64'd0);
    end
    if (second_start) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    k = 0;
    while (done_cnt == done_base && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("done_count", 64'(done_cnt - done_base), 64'd1);
    chk("pop_count", 64'(mon_popped - pop_base), 64'(T * T));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("idle_flags", {61'd0, busy, done, err_unexp}, 64'd0);
  endtask

  initial begin
    int k;
    logic [DW-1:0] r;
    rst_n = 1'b0; start = 1'b0;
    s1_start = 1'b0; s1_rvalid = 1'b0; s1_rdata = '0; s1_ready = 1'b1;
    @(negedge clk); #1;
    chk("reset_outputs", {13'd0, busy, done, err_unexp, score_re, score_tq, score_tk, out_valid,
                          out_data, out_tq, out_tk, out_last_row, out_last}, 64'd0);
    chk("reset_outputs_t1", {25'd0, s1_busy, s1_done, s1_err, s1_re, s1_tq, s1_tk, s1_valid,
                             s1_data, s1_last_row, s1_last}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_drain(1, 1, 0, 0, 0);
    run_drain(3, 3, 2, 0, 1);
    run_drain(1, 5, 1, 0, 1);
    run_drain(1, 1, 0, 1, 1);
    run_drain(2, 2, 0, 0, 1);

    // Reset in the middle of a drain, then a stray return while idle
    lat_lo = 1; lat_hi = 1; rdy_mode = 0;
    load_run(1);
    k = mon_popped;
    pulse_start();
    while (mon_popped - k < 10 && cyc < 90000) @(negedge clk);
    #2;
    rst_n = 1'b0; resp_flush = 1'b1;
    @(negedge clk); #1;
    chk("midrun_reset_outputs", {13'd0, busy, done, err_unexp, score_re, score_tq, score_tk,
                                 out_valid, out_data, out_tq, out_tk, out_last_row, out_last}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk); resp_flush = 1'b0;
    @(negedge clk); inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    @(negedge clk); #1;
    chk("stray_return_flag", {61'd0, err_unexp, out_valid, busy}, 64'b100);
    run_drain(1, 3, 1, 0, 1);

    // Single-token matrix
    r = $urandom;
    @(negedge clk); s1_start = 1'b1;
    @(negedge clk); s1_start = 1'b0;
    k = 0;
    while (!s1_re && k < 20) begin @(negedge clk); k++; end
    chk("t1_request", {61'd0, s1_re, s1_tq, s1_tk}, 64'b100);
    @(negedge clk); s1_rvalid = 1'b1; s1_rdata = r;
    chk("t1_single_request", {63'd0, s1_re}, 64'd0);
    @(negedge clk); s1_rvalid = 1'b0; s1_rdata = '0;
    chk("t1_output", {27'd0, s1_valid, s1_data, s1_otq, s1_otk, s1_last_row, s1_last},
        {27'd0, 1'b1, r, 1'b0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    chk("t1_done", {61'd0, s1_done, s1_busy, s1_valid}, 64'b100);
    @(negedge clk);
    chk("t1_idle", {61'd0, s1_done, s1_busy, s1_err}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
